// File: rtl/cic_comp_fir.sv
// -----------------------------------------------------------------------------
// cic_comp_fir
//   Folded, time-multiplexed 9-tap symmetric FIR that compensates CIC passband
//   droop. One pre-add + multiply + accumulate per clock over the five unique
//   coefficients. R == 1 means the CIC adds no droop, so samples pass through
//   untouched. The delay line keeps its contents and no MAC cycles are spent.
//
//   Optional feature macro: CIC_COMP_SAT_EN
//     defined   : the rounded result is clipped to the DATA_WIDTH range and
//                 sat_flag records every clip.
//     undefined : the rounded result wraps (two's complement) and sat_flag is
//                 tied to 0.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   R              CIC decimation factor, sampled at accept (1 = bypass)
//   in_valid       single-cycle strobe, sample on in_data
//   in_data        signed input sample
//   in_ready       high when a sample can be accepted (IDLE or OUT)
//   out_valid      single-cycle strobe, result on out_data
//   out_data       signed result, held between strobes
//   coef_wr_en     shadow coefficient write enable
//   coef_addr      shadow coefficient index (0..4; higher addresses ignored)
//   coef_data      signed Q2.14 coefficient
//   coef_commit    request shadow -> active copy at the next accept
//   overrun        sticky: a sample arrived while in_ready was low
//   sat_flag       sticky: an output was clipped
//   sat_clr        clears overrun and sat_flag (a same-cycle new event wins)
//   dbg_state      current FSM state (0 IDLE, 1 MAC, 2 OUT)
//
// Handshake: a sample is taken on any clock edge where in_valid and in_ready
// are both high. in_valid while in_ready is low drops the sample and sets
// overrun. There is no output back-pressure: out_valid is a one-cycle pulse.
// -----------------------------------------------------------------------------
module cic_comp_fir #(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int TAPS       = 9,
    parameter int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4:0]            R,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  coef_wr_en,
    input  logic [2:0]            coef_addr,
    input  logic [COEF_WIDTH-1:0] coef_data,
    input  logic                  coef_commit,
    output logic                  overrun,
    output logic                  sat_flag,
    input  logic                  sat_clr,
    output logic [1:0]            dbg_state
);

    localparam int U    = (TAPS + 1) / 2;     // unique coefficients
    localparam int IW   = $clog2(TAPS);       // delay-line index width
    localparam int UIW  = $clog2(U);          // coefficient index width
    localparam int FRAC = COEF_WIDTH - 2;     // Q2.14 fraction bits

    localparam logic signed [COEF_WIDTH-1:0] COEF_ONE = COEF_WIDTH'(1 <<< FRAC);
    localparam logic signed [ACC_WIDTH-1:0]  RND_BIAS = ACC_WIDTH'(1 <<< (FRAC - 1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                        state;
    logic signed [DATA_WIDTH-1:0]  x      [TAPS];
    logic signed [COEF_WIDTH-1:0]  shadow [U];
    logic signed [COEF_WIDTH-1:0]  active [U];
    logic signed [ACC_WIDTH-1:0]   acc;
    logic        [IW-1:0]          k;
    logic                          commit_pend;

    logic                          accept;
    logic                          drop;
    logic                          bypass_sel;
    logic        [IW-1:0]          mirror_idx;
    logic signed [DATA_WIDTH-1:0]  pre_a;
    logic signed [DATA_WIDTH-1:0]  pre_b;
    logic signed [DATA_WIDTH:0]    pre;
    logic signed [COEF_WIDTH-1:0]  coef;
    logic signed [DATA_WIDTH+COEF_WIDTH:0] prod;
    logic signed [ACC_WIDTH-1:0]   acc_next;
    logic signed [ACC_WIDTH-1:0]   rnd;
    logic        [DATA_WIDTH-1:0]  res;
    logic                          last_mac;
    logic                          clip;

    assign in_ready   = (state == IDLE) || (state == OUT);
    assign accept     = in_valid && in_ready;
    assign drop       = in_valid && !in_ready;
    assign bypass_sel = (R == 5'd1);
    assign dbg_state  = state;
    assign last_mac   = (state == MAC) && (k == IW'(U - 1));

    // Folded datapath: tap k pairs with its mirror TAPS-1-k. The centre tap
    // has no partner, so its second pre-add operand is forced to zero.
    assign mirror_idx = IW'(TAPS - 1) - k;
    assign pre_a      = x[k];
    assign pre_b      = (k == IW'(U - 1)) ? '0 : x[mirror_idx];
    assign pre        = $signed({pre_a[DATA_WIDTH-1], pre_a}) + $signed({pre_b[DATA_WIDTH-1], pre_b});
    assign coef       = active[k[UIW-1:0]];
    assign prod       = pre * coef;
    assign acc_next   = acc + ACC_WIDTH'(prod);

    // Round half up, then drop the Q2.14 fraction.
    assign rnd = acc_next + RND_BIAS;

`ifdef CIC_COMP_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = ACC_WIDTH'((1 <<< (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = ACC_WIDTH'(-(1 <<< (DATA_WIDTH - 1)));
    logic signed [ACC_WIDTH-1:0] shr;
    assign shr = rnd >>> FRAC;

    always_comb begin
        res  = shr[DATA_WIDTH-1:0];
        clip = 1'b0;
        if (shr > OUT_MAX) begin
            res  = OUT_MAX[DATA_WIDTH-1:0];
            clip = 1'b1;
        end else if (shr < OUT_MIN) begin
            res  = OUT_MIN[DATA_WIDTH-1:0];
            clip = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
        end else begin
            sat_flag <= (sat_flag && !sat_clr) || (last_mac && clip);
        end
    end
`else
    assign res      = DATA_WIDTH'(rnd >>> FRAC);
    assign clip     = 1'b0;
    assign sat_flag = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            k           <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            overrun     <= 1'b0;
            commit_pend <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                x[i] <= '0;
            end
            for (int i = 0; i < U; i++) begin
                shadow[i] <= (i == U - 1) ? COEF_ONE : '0;
                active[i] <= (i == U - 1) ? COEF_ONE : '0;
            end
        end else begin
            out_valid <= 1'b0;
            overrun   <= (overrun && !sat_clr) || drop;

            if (coef_wr_en && (coef_addr < 3'(U))) begin
                shadow[coef_addr[UIW-1:0]] <= coef_data;
            end

            // The bank only switches at an accept edge, so a running
            // computation always sees one consistent bank. The copy takes the
            // shadow contents from before any same-edge shadow write.
            commit_pend <= accept ? 1'b0 : (commit_pend || coef_commit);
            if (accept && (commit_pend || coef_commit)) begin
                for (int i = 0; i < U; i++) begin
                    active[i] <= shadow[i];
                end
            end

            case (state)
                IDLE, OUT: begin
                    if (in_valid) begin
                        if (bypass_sel) begin
                            out_data  <= in_data;
                            out_valid <= 1'b1;
                            state     <= OUT;
                        end else begin
                            for (int i = TAPS - 1; i > 0; i--) begin
                                x[i] <= x[i-1];
                            end
                            x[0]  <= in_data;
                            acc   <= '0;
                            k     <= '0;
                            state <= MAC;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    k   <= k + 1'b1;
                    if (last_mac) begin
                        out_data  <= res;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cic_comp_fir.sv
// -----------------------------------------------------------------------------
// tb_cic_comp_fir
//   Drives cic_comp_fir cycle by cycle. A reference model written directly from
//   the filter definition (direct-form symmetric impulse response, sample
//   history queue, accept/busy timing) predicts every out_valid, out_data,
//   in_ready, overrun and sat_flag value.
// -----------------------------------------------------------------------------
module tb_cic_comp_fir;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [4:0]  r_sel = 5'd2;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        coef_wr_en = 1'b0;
    logic [2:0]  coef_addr = '0;
    logic [15:0] coef_data = '0;
    logic        coef_commit = 1'b0;
    logic        overrun;
    logic        sat_flag;
    logic        sat_clr = 1'b0;
    logic [1:0]  dbg_state;

    cic_comp_fir dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .R           (r_sel),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .coef_wr_en  (coef_wr_en),
        .coef_addr   (coef_addr),
        .coef_data   (coef_data),
        .coef_commit (coef_commit),
        .overrun     (overrun),
        .sat_flag    (sat_flag),
        .sat_clr     (sat_clr),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- model state ----------------
    int                 n_cmp = 0;
    int                 n_err = 0;
    int                 cyc = 0;
    int                 ready_at = 0;
    logic signed [15:0] hist [9];
    logic signed [15:0] shd [5];
    logic signed [15:0] act [5];
    logic               pend = 1'b0;
    logic               m_ovr = 1'b0;
    logic               m_sat = 1'b0;
    logic [15:0]        last_data = '0;
    logic [15:0]        exp_q[$];
    int                 exp_t_q[$];
    logic               exp_clip_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 9; i++) hist[i] = '0;
        for (int i = 0; i < 5; i++) begin
            shd[i] = (i == 4) ? 16'sd16384 : 16'sd0;
            act[i] = shd[i];
        end
        pend      = 1'b0;
        m_ovr     = 1'b0;
        m_sat     = 1'b0;
        last_data = '0;
        ready_at  = 0;
        exp_q.delete();
        exp_t_q.delete();
        exp_clip_q.delete();
    endtask

    // y = sum over all 9 taps of h[i]*x[i], h symmetric about the centre tap.
    function automatic void model_filter(output logic [15:0] y, output logic clip);
        longint acc;
        longint r;
        int     ci;
        acc = 0;
        for (int i = 0; i < 9; i++) begin
            ci  = (i <= 4) ? i : 8 - i;
            acc = acc + longint'(hist[i]) * longint'(act[ci]);
        end
        r = (acc + 64'sd8192) >>> 14;
`ifdef CIC_COMP_SAT_EN
        if (r > 32767) begin
            y = 16'h7fff; clip = 1'b1;
        end else if (r < -32768) begin
            y = 16'h8000; clip = 1'b1;
        end else begin
            y = r[15:0]; clip = 1'b0;
        end
`else
        y    = r[15:0];
        clip = 1'b0;
`endif
    endfunction

    // ---------------- driver: one clock edge ----------------
    task automatic step();
        int          n;
        logic        acc_ok;
        logic        ovr_evt;
        logic        clr;
        logic        exp_v;
        logic        sat_evt;
        logic [15:0] y;
        logic        c;
        n       = cyc + 1;
        acc_ok  = in_valid && (n >= ready_at);
        ovr_evt = in_valid && !acc_ok;
        if (acc_ok) begin
            if (pend || coef_commit) begin
                for (int i = 0; i < 5; i++) act[i] = shd[i];
            end
            if (r_sel == 5'd1) begin
                exp_q.push_back(in_data); exp_t_q.push_back(n); exp_clip_q.push_back(1'b0);
                ready_at = n + 1;
            end else begin
                for (int i = 8; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = in_data;
                model_filter(y, c);
                exp_q.push_back(y); exp_t_q.push_back(n + 5); exp_clip_q.push_back(c);
                ready_at = n + 6;
            end
        end
        pend = acc_ok ? 1'b0 : (pend || coef_commit);
        if (coef_wr_en && coef_addr < 3'd5) shd[coef_addr] = coef_data;
        clr = sat_clr;

        @(posedge clk);
        #1;
        cyc         = n;
        in_valid    = 1'b0;
        coef_wr_en  = 1'b0;
        coef_commit = 1'b0;
        sat_clr     = 1'b0;

        exp_v   = 1'b0;
        sat_evt = 1'b0;
        if (exp_t_q.size() > 0 && exp_t_q[0] == cyc) begin
            exp_v     = 1'b1;
            last_data = exp_q.pop_front();
            sat_evt   = exp_clip_q.pop_front();
            void'(exp_t_q.pop_front());
        end
        m_ovr = (m_ovr && !clr) || ovr_evt;
        m_sat = (m_sat && !clr) || sat_evt;

        check("out_valid", 32'(out_valid), 32'(exp_v));
        check("out_data",  32'(out_data),  32'(last_data));
        check("in_ready",  32'(in_ready),  32'(cyc + 1 >= ready_at));
        check("overrun",   32'(overrun),   32'(m_ovr));
        check("sat_flag",  32'(sat_flag),  32'(m_sat));
    endtask

    task automatic idle(input int ncyc);
        for (int i = 0; i < ncyc; i++) step();
    endtask

    task automatic send(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((cyc + 1 < ready_at || exp_t_q.size() > 0) && guard < 50) begin
            step();
            guard++;
        end
        check("wait_idle_timeout", 32'(guard >= 50), 32'd0);
    endtask

    task automatic write_coef(input logic [2:0] a, input logic [15:0] d);
        coef_wr_en = 1'b1;
        coef_addr  = a;
        coef_data  = d;
        step();
    endtask

    task automatic reset_dut();
        in_valid    = 1'b0;
        coef_wr_en  = 1'b0;
        coef_commit = 1'b0;
        sat_clr     = 1'b0;
        rst_n       = 1'b0;
        model_reset();
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_overrun",   32'(overrun),   32'd0);
        check("rst_sat_flag",  32'(sat_flag),  32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] ir [9];
        ir = '{16'd1000, 16'hf830, 16'd3000, 16'd500, 16'd16384,
               16'd500, 16'd3000, 16'hf830, 16'd1000};
        model_reset();
        #2;
        reset_dut();

        // Identity bank, R=2: impulse of 1000 then zeros at the max rate.
        r_sel = 5'd2;
        send(16'd1000); idle(5);
        for (int i = 0; i < 8; i++) begin send(16'd0); idle(5); end

        // New bank 1000,-2000,3000,500,16384 via commit, R=4, impulse 16384.
        write_coef(3'd0, 16'd1000);
        write_coef(3'd1, 16'hf830);
        write_coef(3'd2, 16'd3000);
        write_coef(3'd3, 16'd500);
        write_coef(3'd4, 16'd16384);
        coef_commit = 1'b1; step();
        r_sel = 5'd4;
        for (int i = 0; i < 9; i++) begin
            send(i == 0 ? 16'd16384 : 16'd0);
            idle(5);
            check("impulse_tap", 32'(last_data), 32'(ir[i]));
        end

        // Bypass: 5 back-to-back samples, then zeros through the filter.
        r_sel = 5'd1;
        for (int i = 0; i < 5; i++) send(16'($urandom_range(0, 65535)));
        r_sel = 5'd2;
        for (int i = 0; i < 3; i++) begin send(16'd0); idle(5); end
        check("bypass_keeps_line", 32'(last_data), 32'd0);

        // Overrun: second sample two cycles into the MAC is dropped.
        send(16'd700); idle(1); send(16'd555); wait_idle();
        sat_clr = 1'b1; step();

        // Saturation: c0..c3 = 1.0, c4 = 0, nine full-scale samples.
        write_coef(3'd0, 16'd16384);
        write_coef(3'd1, 16'd16384);
        write_coef(3'd2, 16'd16384);
        write_coef(3'd3, 16'd16384);
        write_coef(3'd4, 16'd0);
        coef_commit = 1'b1;
        send(16'd32767); idle(5);
        for (int i = 0; i < 8; i++) begin send(16'd32767); idle(5); end
`ifdef CIC_COMP_SAT_EN
        check("sat_full_scale", 32'(last_data), 32'h7fff);
`else
        check("wrap_full_scale", 32'(last_data), 32'hfff8);
`endif
        sat_clr = 1'b1; step();

        // Randomized traffic: mixed modes, coefficient updates, clears.
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 2) == 0);
            in_data  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 65535))
                                                    : 16'($signed(10'($urandom_range(0, 1023))));
            if ($urandom_range(0, 7) == 0) r_sel = 5'($urandom_range(1, 31));
            if ($urandom_range(0, 19) == 0) begin
                coef_wr_en = 1'b1;
                coef_addr  = 3'($urandom_range(0, 7));
                coef_data  = 16'($urandom_range(0, 65535));
            end
            coef_commit = ($urandom_range(0, 29) == 0);
            sat_clr     = ($urandom_range(0, 24) == 0);
            step();
        end

        // Reset during the MAC (cycle T+3) with overrun set.
        wait_idle();
        r_sel = 5'd2;
        send(16'd1234); idle(1); send(16'd99);
        reset_dut();
        r_sel = 5'd2;
        send(16'd1000); idle(5);
        check("post_reset_impulse", 32'(last_data), 32'd0);
        send(16'd0); idle(5);
        send(16'd0); idle(5);
        send(16'd0); idle(5);
        send(16'd0); idle(5);
        check("post_reset_centre", 32'(last_data), 32'd1000);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
